// File: rtl/home_cmd_uart.sv
// UART command endpoint: receives command bytes, drives device on/off
// outputs and answers every command with a one-byte response frame.
// RX and TX share a free-running 16x oversample tick and run independently;
// a single pending-response slot sits between command execution and TX.
module home_cmd_uart #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int NUM_DEV    = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rx,
  output logic               o_tx,
  output logic [NUM_DEV-1:0] o_dev_ctrl,
  output logic [7:0]         o_rx_data,
  output logic               o_rx_valid,
  output logic               o_tx_busy,
  output logic               o_err_frame,
  output logic               o_err_overrun
);

  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [3:0]    NDEV      = 4'(NUM_DEV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [TW-1:0]      r_tick_cnt;
  logic               w_tick;
  logic               r_rx_meta, r_rx_sync;
  logic [1:0]         r_rx_state;
  logic [3:0]         r_rx_tcnt;
  logic [2:0]         r_rx_bitcnt;
  logic [7:0]         r_rx_shift;
  logic               r_rx_armed;
  logic [7:0]         r_rx_data;
  logic               r_rx_valid;
  logic               r_ferr_pls;
  logic               r_err_frame;
  logic [NUM_DEV-1:0] r_dev;
  logic               r_pend_full;
  logic [7:0]         r_pend_data;
  logic               r_err_ovr;
  logic               r_tx_busy;
  logic [9:0]         r_tx_shift;
  logic [3:0]         r_tx_tcnt;
  logic [3:0]         r_tx_bitcnt;

  logic               w_resp_wr;
  logic [7:0]         w_resp;
  logic [NUM_DEV-1:0] w_dev_nxt;
  logic [2:0]         w_idx;
  logic [NUM_DEV-1:0] w_mask;
  logic               w_tx_load;

  assign w_tick    = (r_tick_cnt == TICK_LAST);
  assign w_idx     = r_rx_data[2:0];
  assign w_mask    = NUM_DEV'(1) << w_idx;
  assign w_tx_load = r_pend_full & ~r_tx_busy;

  // Free-running oversample tick divider
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // Two-flop synchroniser; resets low so a genuine high must be seen first
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rx_meta <= 1'b0;
      r_rx_sync <= 1'b0;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // RX framing FSM: mid-bit sampling, stop check, frame-error flagging
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rx_state  <= S_IDLE;
      r_rx_tcnt   <= '0;
      r_rx_bitcnt <= '0;
      r_rx_shift  <= '0;
      r_rx_armed  <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_ferr_pls  <= 1'b0;
      r_err_frame <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_ferr_pls <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          // armed only once the line has been seen idle-high
          if (r_rx_sync) r_rx_armed <= 1'b1;
          else if (r_rx_armed) begin
            r_rx_state <= S_START;
            r_rx_tcnt  <= '0;
          end
        end
        S_START: if (w_tick) begin
          if (r_rx_tcnt == 4'd7) begin
            r_rx_tcnt   <= '0;
            r_rx_bitcnt <= '0;
            r_rx_state  <= r_rx_sync ? S_IDLE : S_DATA;
          end else r_rx_tcnt <= r_rx_tcnt + 1'b1;
        end
        S_DATA: if (w_tick) begin
          if (r_rx_tcnt == 4'd15) begin
            r_rx_tcnt  <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            if (r_rx_bitcnt == 3'd7) r_rx_state <= S_STOP;
            else                     r_rx_bitcnt <= r_rx_bitcnt + 1'b1;
          end else r_rx_tcnt <= r_rx_tcnt + 1'b1;
        end
        default: if (w_tick) begin
          if (r_rx_tcnt == 4'd15) begin
            r_rx_tcnt  <= '0;
            r_rx_state <= S_IDLE;
            r_rx_armed <= 1'b0;
            if (r_rx_sync) begin
              r_rx_data  <= r_rx_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_err_frame <= 1'b1;
              r_ferr_pls  <= 1'b1;
            end
          end else r_rx_tcnt <= r_rx_tcnt + 1'b1;
        end
      endcase
    end
  end

  // Command decode and response selection, one clock after rx_valid
  always_comb begin
    w_resp_wr = 1'b0;
    w_resp    = 8'h00;
    w_dev_nxt = r_dev;
    if (r_rx_valid) begin
      w_resp_wr = 1'b1;
      if (r_rx_data[5:3] != 3'b000 || {1'b0, w_idx} >= NDEV) begin
        w_resp = 8'hE0;
      end else begin
        case (r_rx_data[7:6])
          2'b00: begin
            w_dev_nxt = r_dev & ~w_mask;
            w_resp    = {4'hA, 1'b0, w_idx};
          end
          2'b01: begin
            w_dev_nxt = r_dev | w_mask;
            w_resp    = {4'hA, 1'b0, w_idx};
          end
          2'b10: begin
            w_dev_nxt = r_dev ^ w_mask;
            w_resp    = {4'hA, 1'b0, w_idx};
          end
          default: w_resp = 8'(r_dev);
        endcase
      end
    end else if (r_ferr_pls) begin
      w_resp_wr = 1'b1;
      w_resp    = 8'hE1;
    end
  end

  // Device state and single pending-response slot; a full slot drops new responses
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_dev       <= '0;
      r_pend_full <= 1'b0;
      r_pend_data <= '0;
      r_err_ovr   <= 1'b0;
    end else begin
      r_dev <= w_dev_nxt;
      if (w_tx_load) r_pend_full <= 1'b0;
      if (w_resp_wr) begin
        if (r_pend_full && !w_tx_load) r_err_ovr <= 1'b1;
        else begin
          r_pend_full <= 1'b1;
          r_pend_data <= w_resp;
        end
      end
    end
  end

  // TX serialiser: start, 8 data LSB first, stop, 16 ticks per bit
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tx_busy   <= 1'b0;
      r_tx_shift  <= '1;
      r_tx_tcnt   <= '0;
      r_tx_bitcnt <= '0;
    end else if (!r_tx_busy) begin
      if (r_pend_full) begin
        r_tx_busy   <= 1'b1;
        r_tx_shift  <= {1'b1, r_pend_data, 1'b0};
        r_tx_tcnt   <= '0;
        r_tx_bitcnt <= '0;
      end
    end else if (w_tick) begin
      if (r_tx_tcnt == 4'd15) begin
        r_tx_tcnt  <= '0;
        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
        if (r_tx_bitcnt == 4'd9) r_tx_busy   <= 1'b0;
        else                     r_tx_bitcnt <= r_tx_bitcnt + 1'b1;
      end else r_tx_tcnt <= r_tx_tcnt + 1'b1;
    end
  end

  assign o_tx          = r_tx_busy ? r_tx_shift[0] : 1'b1;
  assign o_tx_busy     = r_tx_busy;
  assign o_dev_ctrl    = r_dev;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_err_frame   = r_err_frame;
  assign o_err_overrun = r_err_ovr;

endmodule

// File: doc/home_cmd_uart.md
HOME_CMD_UART -- requirements
Module: home_cmd_uart

Interface
REQ-001 The block SHALL have parameter CLOCK_FREQ, default 50000000, system clock in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 9600, UART bit rate.
REQ-003 The block SHALL have parameter NUM_DEV, default 4, legal range 1..8, number of controlled device channels.
REQ-004 The block SHALL derive DIV = CLOCK_FREQ/(BAUD_RATE*16) as a local constant, the 16x oversample tick divisor (DIV >= 1).
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 rx  input  1  UART serial in, asynchronous to clk, idle high.
REQ-008 tx  output  1  UART serial out, idle high.
REQ-009 dev_ctrl  output  NUM_DEV  device on/off outputs, bit i = device i.
REQ-010 rx_data  output  8  last correctly framed received byte.
REQ-011 rx_valid  output  1  one-clock pulse per correctly framed byte.
REQ-012 tx_busy  output  1  high while a response frame is on tx.
REQ-013 err_frame  output  1  sticky; set on a stop-bit error.
REQ-014 err_overrun  output  1  sticky; set on a dropped response.

Function
REQ-015 rx SHALL pass through a 2-flop synchroniser before any use.
REQ-016 A tick SHALL occur every DIV clocks; the tick counter SHALL free-run from reset.
REQ-017 RX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-018 RX FSM SHALL go IDLE->START on synchronised rx = 0.
REQ-019 In START, rx SHALL be sampled at tick 8; a 1 (false start) SHALL return the FSM to IDLE with no output.
REQ-020 In DATA, the FSM SHALL sample 8 bits LSB first, each at tick 8 of its 16-tick bit.
REQ-021 In STOP, rx SHALL be sampled at tick 8.
REQ-022 A stop sample of 1 SHALL update rx_data and pulse rx_valid for exactly one clock.
REQ-023 A stop sample of 0 SHALL set err_frame, leave rx_data unchanged, execute no command and send response 8'hE1.
REQ-024 In every stop case the RX FSM SHALL then return to IDLE and wait for rx = 1 before a new start is accepted.
REQ-025 The command byte SHALL be decoded as: [7:6] opcode (00 OFF, 01 ON, 10 TOGGLE, 11 QUERY), [5:3] reserved, [2:0] device index idx.
REQ-026 A command SHALL be invalid when [5:3] != 0 or idx >= NUM_DEV; an invalid command SHALL leave dev_ctrl unchanged and send response 8'hE0.
REQ-027 A valid OFF, ON or TOGGLE SHALL update dev_ctrl[idx] on the clock after rx_valid and send response {4'hA, 1'b0, idx}.
REQ-028 A valid QUERY SHALL leave dev_ctrl unchanged and send response dev_ctrl zero-extended to 8 bits.
REQ-029 The block SHALL hold one pending-response register.
REQ-030 TX SHALL load the pending response within 2 clocks of it being written when tx is idle.
REQ-031 If a new response arrives while the pending register is full, the command SHALL still execute, the new response SHALL be dropped and err_overrun SHALL be set.
REQ-032 The TX frame SHALL be a start bit 0, 8 data bits LSB first, then stop bit 1, each exactly 16 ticks long.
REQ-033 tx_busy SHALL assert on the clock the start bit begins and SHALL deassert at the end of the stop bit.
REQ-034 Back-to-back frames SHALL carry no idle gap beyond 2 clocks.
REQ-035 RX and TX SHALL operate concurrently; a command received during transmission SHALL be queued in the pending register.

Reset
REQ-036 While rst = 0, both FSMs SHALL go to IDLE, tx = 1, tx_busy = 0, dev_ctrl = 0, rx_data = 8'h00, rx_valid = 0, err_frame = 0, err_overrun = 0, pending register empty, all counters 0.
REQ-037 Reset asserted mid-frame SHALL abort that frame immediately, without completing it or sending a response.
REQ-038 After release, the block SHALL accept a new start bit only after rx has been seen high.

Verification
REQ-039 NUM_DEV=4, DIV=1: send 8'h42 -> rx_valid pulse, dev_ctrl=4'b0100, tx frame 8'hA2.
REQ-040 Then send 8'h82 followed by 8'hC0 -> dev_ctrl=4'b0000, then 8'hA2 and 8'h00 transmitted back-to-back.
REQ-041 Send 8'h45 (idx >= NUM_DEV) and send 8'h48 (reserved bits set) -> dev_ctrl unchanged, 8'hE0 sent for each.
REQ-042 Send a frame with stop bit 0 -> err_frame=1, no rx_valid, 8'hE1 sent; a 4-tick low glitch -> no activity.
REQ-043 Send three commands back-to-back (8'h41, 8'h42, 8'h43) -> all three executed, dev_ctrl=4'b1110, err_overrun=1, third response dropped.
REQ-044 Assert rst mid TX data bit 3 -> tx=1 within the same cycle, all outputs at reset values, the next command works normally.
